// File: rtl/traffic_timer_if.sv
// rtl/traffic_timer_if.sv - traffic_timer night request and lamp/display bundle
interface traffic_timer_if;
    logic       night;
    logic [4:0] count;
    logic       LR1;
    logic       eLED01;
    logic       eLED23;
    logic       red1;
    logic       yel1;
    logic       grn1;
    logic       red2;
    logic       yel2;
    logic       grn2;
    logic       tick;

    modport master (
        output night,
        input  count, LR1, eLED01, eLED23,
        input  red1, yel1, grn1, red2, yel2, grn2, tick
    );

    modport slave (
        input  night,
        output count, LR1, eLED01, eLED23,
        output red1, yel1, grn1, red2, yel2, grn2, tick
    );
endinterface

// File: rtl/traffic_timer.sv
// rtl/traffic_timer.sv - two-way traffic light timer with 1 s prescaler and night flash mode
module traffic_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int RED_TIME = 29
) (
    input  logic          clk,
    input  logic          rst,
    traffic_timer_if.slave tif
);

    localparam int             PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [4:0]     RELOAD  = 5'(RED_TIME);
    localparam logic [4:0]     YEL_AT  = 5'd5;

    typedef enum logic {RUN, NIGHT} state_t;

    logic [PW-1:0] pre;
    logic          tick;
    state_t        state, state_n;
    logic [4:0]    cnt, cnt_n;
    logic          lr1, lr1_n;
    logic          blink, blink_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
        end else if (pre == PRE_MAX) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    assign tick = (pre == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= RELOAD;
            lr1   <= 1'b1;
            blink <= 1'b0;
        end else if (tick) begin
            state <= state_n;
            cnt   <= cnt_n;
            lr1   <= lr1_n;
            blink <= blink_n;
        end
    end

    // night is only consumed here, and this result is only latched on tick edges
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lr1_n   = lr1;
        blink_n = blink;
        case (state)
            RUN: begin
                if (tif.night) begin
                    state_n = NIGHT;
                    cnt_n   = RELOAD;
                    lr1_n   = 1'b1;
                    blink_n = 1'b1;
                end else if (cnt == '0) begin
                    cnt_n = RELOAD;
                    lr1_n = ~lr1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            NIGHT: begin
                if (tif.night) begin
                    blink_n = ~blink;
                end else begin
                    state_n = RUN;
                    cnt_n   = RELOAD;
                    lr1_n   = 1'b1;
                    blink_n = 1'b0;
                end
            end
            default: state_n = RUN;
        endcase
    end

    logic nr_grn, nr_yel, nr_en;
    logic e01, e23, r1, y1, g1, r2, y2, g2;

    always_comb begin
        // the running side shows count-5, so its digits blank below 5
        nr_grn = (cnt > YEL_AT);
        nr_yel = ~nr_grn;
        nr_en  = (cnt >= YEL_AT);
        e01 = 1'b0; e23 = 1'b0;
        r1  = 1'b0; y1  = 1'b0; g1 = 1'b0;
        r2  = 1'b0; y2  = 1'b0; g2 = 1'b0;
        if (state == NIGHT) begin
            y1 = blink;
            y2 = blink;
        end else if (lr1) begin
            r1  = 1'b1;
            e01 = 1'b1;
            g2  = nr_grn;
            y2  = nr_yel;
            e23 = nr_en;
        end else begin
            r2  = 1'b1;
            e23 = 1'b1;
            g1  = nr_grn;
            y1  = nr_yel;
            e01 = nr_en;
        end
    end

    assign tif.count  = cnt;
    assign tif.LR1    = lr1;
    assign tif.tick   = tick;
    assign tif.eLED01 = e01;
    assign tif.eLED23 = e23;
    assign tif.red1   = r1;
    assign tif.yel1   = y1;
    assign tif.grn1   = g1;
    assign tif.red2   = r2;
    assign tif.yel2   = y2;
    assign tif.grn2   = g2;

endmodule

// File: tb/tb_traffic_timer.sv
// tb/tb_traffic_timer.sv - random night/reset stimulus against a tick-level reference model
module tb_traffic_timer;

    localparam int TD = 4;
    localparam int RT = 29;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    traffic_timer_if tif ();

    traffic_timer #(.TICK_DIV(TD), .RED_TIME(RT)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: night-mode flag, phase seconds, red side, flash phase, edges since release
    bit m_nm;
    int m_cnt;
    bit m_lr1;
    bit m_blink;
    int m_cyc;

    function automatic void m_reset();
        m_nm = 0; m_cnt = RT; m_lr1 = 1; m_blink = 0; m_cyc = 0;
    endfunction

    function automatic void m_second(input bit nt);
        if (!m_nm) begin
            if (nt) begin
                m_nm = 1; m_cnt = RT; m_lr1 = 1; m_blink = 1;
            end else if (m_cnt == 0) begin
                m_cnt = RT; m_lr1 = !m_lr1;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end else if (nt) begin
            m_blink = !m_blink;
        end else begin
            m_nm = 0; m_cnt = RT; m_lr1 = 1; m_blink = 0;
        end
    endfunction

    function automatic bit m_tick();
        return !rst && (m_cyc % TD == TD - 1);
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_reset();
        end else begin
            if (m_tick()) m_second(tif.night);
            m_cyc = m_cyc + 1;
        end
    endfunction

    // {eLED01, eLED23, red1, yel1, grn1, red2, yel2, grn2}
    function automatic logic [7:0] exp_lamps();
        logic [7:0] v;
        bit g, e;
        if (m_nm) begin
            v = {2'b00, 1'b0, m_blink, 1'b0, 1'b0, m_blink, 1'b0};
        end else begin
            g = (m_cnt > 5);
            e = (m_cnt >= 5);
            if (m_lr1) v = {1'b1, e, 1'b1, 1'b0, 1'b0, 1'b0, !g, g};
            else       v = {e, 1'b1, 1'b0, !g, g, 1'b1, 1'b0, 1'b0};
        end
        return v;
    endfunction

    task automatic check_all();
        check("count", tif.count, m_cnt);
        check("LR1", tif.LR1, m_lr1);
        check("tick", tif.tick, m_tick());
        check("lamps", {tif.eLED01, tif.eLED23, tif.red1, tif.yel1, tif.grn1,
                        tif.red2, tif.yel2, tif.grn2}, exp_lamps());
        if (!m_nm) begin
            check("one_lamp1", $countones({tif.red1, tif.yel1, tif.grn1}), 1);
            check("one_lamp2", $countones({tif.red2, tif.yel2, tif.grn2}), 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run_until(input int cnt, input bit lr1, input int budget);
        int k = 0;
        while (!(m_cnt == cnt && m_lr1 == lr1 && !m_nm) && k < budget) begin
            step();
            k++;
        end
        check("reach_phase", k < budget, 1);
    endtask

    initial begin
        rst = 1'b1;
        tif.night = 1'b0;
        m_reset();
        repeat (3) step();
        check("rst_count", tif.count, 29);
        check("rst_red1", tif.red1, 1);
        check("rst_grn2", tif.grn2, 1);
        check("rst_en", {tif.eLED01, tif.eLED23}, 2'b11);
        #2 rst = 1'b0;

        repeat (TD) step();
        check("first_tick_count", tif.count, 28);
        check("first_tick_lr1", tif.LR1, 1);

        repeat (29 * TD) step();
        check("swap_count", tif.count, 29);
        check("swap_lr1", tif.LR1, 0);
        check("swap_red2_grn1", {tif.red2, tif.grn1}, 2'b11);

        run_until(17, 0, 2000);
        tif.night = 1'b1;
        repeat (TD - 1) step();
        check("night_pending_count", tif.count, 17);
        step();
        check("night_count", tif.count, 29);
        check("night_en", {tif.eLED01, tif.eLED23}, 2'b00);
        check("night_yel", {tif.yel1, tif.yel2}, 2'b11);
        repeat (TD) step();
        check("night_blink0", {tif.yel1, tif.yel2}, 2'b00);
        repeat (TD) step();
        check("night_blink1", {tif.yel1, tif.yel2}, 2'b11);

        tif.night = 1'b0;
        repeat (TD) step();
        check("day_count", tif.count, 29);
        check("day_lamps", {tif.LR1, tif.red1, tif.grn2}, 3'b111);

        run_until(10, 0, 2000);
        step();
        #3 rst = 1'b1;
        #1 m_reset();
        check_all();
        check("async_rst_count", tif.count, 29);
        check("async_rst_lr1", tif.LR1, 1);
        step();
        rst = 1'b0;
        repeat (2 * TD) step();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) tif.night = ~tif.night;
            if ($urandom_range(499) == 0) begin
                #3 rst = 1'b1;
                #1 m_reset();
                check_all();
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
